// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-style PIC control logic.
// Field positions follow the 8259 ICW/OCW programming model.
package pic_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned LEVEL_W    = 3;
  localparam int unsigned VEC_BASE_W = DATA_W - LEVEL_W;
  localparam int unsigned COUNT_W    = 2;
  localparam int unsigned OCW2_CMD_W = 3;

  localparam int unsigned ICW1_IC4_BIT  = 0;
  localparam int unsigned ICW1_SNGL_BIT = 1;
  localparam int unsigned ICW1_LTIM_BIT = 3;
  localparam int unsigned ICW1_ID_BIT   = 4;
  localparam int unsigned OCW3_SEL_BIT  = 3;
  localparam int unsigned ICW4_AEOI_BIT = 1;

  // OCW2 {R, SL, EOI} command codes
  localparam logic [OCW2_CMD_W-1:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [OCW2_CMD_W-1:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [OCW2_CMD_W-1:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [OCW2_CMD_W-1:0] OCW2_ROT_AEOI_CLR = 3'b000;

  typedef enum logic [2:0] {
    S_UNINIT    = 3'd0,
    S_WAIT_ICW2 = 3'd1,
    S_WAIT_ICW3 = 3'd2,
    S_WAIT_ICW4 = 3'd3,
    S_READY     = 3'd4
  } init_state_e;

  typedef enum logic [1:0] {
    INTA_IDLE   = 2'd0,
    INTA_FIRST  = 2'd1,
    INTA_SECOND = 2'd2
  } inta_state_e;

  // Configuration latched from ICW1
  typedef struct packed {
    logic ltim;
    logic sngl;
    logic ic4;
  } icw1_cfg_t;

  function automatic logic [COUNT_W-1:0] inta_count_of(input inta_state_e s);
    case (s)
      INTA_FIRST:  return COUNT_W'(1);
      INTA_SECOND: return COUNT_W'(2);
      default:     return COUNT_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/pic_control_logic_if.sv
// Bus, acknowledge and configuration signals of the PIC control logic.
interface pic_control_logic_if;
  import pic_pkg::*;

  logic                  wr_strobe;
  logic                  a0;
  logic [DATA_W-1:0]     din;
  logic                  int_req;
  logic [LEVEL_W-1:0]    isr_level;
  logic                  inta_n;
  logic                  int_out;
  logic [DATA_W-1:0]     dout;
  logic                  dout_en;
  logic                  ready;
  logic                  level_or_edge;
  logic [DATA_W-1:0]     mask;
  logic [COUNT_W-1:0]    inta_count;
  logic                  aeoi;
  logic                  eoi;
  logic                  rotate;

  modport master (
    output wr_strobe, a0, din, int_req, isr_level, inta_n,
    input  int_out, dout, dout_en, ready, level_or_edge, mask,
           inta_count, aeoi, eoi, rotate
  );

  modport slave (
    input  wr_strobe, a0, din, int_req, isr_level, inta_n,
    output int_out, dout, dout_en, ready, level_or_edge, mask,
           inta_count, aeoi, eoi, rotate
  );

endinterface

// File: rtl/pic_inta_sequencer.sv
// Two-pulse INTA handshake: edge detect, acknowledge FSM, request to the
// CPU and vector byte capture/drive.
module pic_inta_sequencer
  import pic_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ready,
  input  logic                  abort,
  input  logic                  inta_n,
  input  logic                  int_req,
  input  logic [VEC_BASE_W-1:0] vec_base,
  input  logic [LEVEL_W-1:0]    isr_level,
  output logic                  int_out,
  output logic [COUNT_W-1:0]    inta_count,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_en
);

  inta_state_e        state_q, state_d;
  logic               inta_n_q;
  logic               fall_c, rise_c;
  logic               int_out_d, dout_en_d, capture_c;
  logic [COUNT_W-1:0] count_d;

  // Delayed copy of the pin for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inta_n_q <= 1'b1;
    else        inta_n_q <= inta_n;
  end

  assign fall_c = inta_n_q & ~inta_n;
  assign rise_c = ~inta_n_q & inta_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INTA_IDLE;
    else        state_q <= state_d;
  end

  // An ICW1 write aborts the handshake regardless of pin activity
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = INTA_IDLE;
    end else begin
      unique case (state_q)
        INTA_IDLE:   if (fall_c && ready) state_d = INTA_FIRST;
        INTA_FIRST:  if (fall_c)          state_d = INTA_SECOND;
        INTA_SECOND: if (rise_c)          state_d = INTA_IDLE;
        default:                          state_d = INTA_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d   = inta_count_of(state_d);
    int_out_d = ready & ~abort & int_req & (state_d == INTA_IDLE);
    dout_en_d = (state_d == INTA_SECOND) & ~inta_n;
    capture_c = (state_q == INTA_FIRST) & (state_d == INTA_SECOND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_out    <= 1'b0;
      inta_count <= '0;
      dout       <= '0;
      dout_en    <= 1'b0;
    end else begin
      int_out    <= int_out_d;
      inta_count <= count_d;
      dout_en    <= dout_en_d;
      if (capture_c) dout <= {vec_base, isr_level};
    end
  end

endmodule

// File: rtl/pic_control_logic.sv
// 8259-style PIC command decoder (ICW1-4, OCW1/2) and initialisation FSM,
// wrapping the INTA acknowledge sequencer.
module pic_control_logic
  import pic_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  pic_control_logic_if.slave  bus
);

  init_state_e             state_q, state_d;
  icw1_cfg_t               cfg_q, cfg_d;
  logic [VEC_BASE_W-1:0]   vec_base_q, vec_base_d;
  logic [DATA_W-1:0]       mask_q, mask_d;
  logic                    aeoi_q, aeoi_d;
  logic                    rotate_q, rotate_d;
  logic                    eoi_q, eoi_d;
  logic                    ready_q;
  logic                    wr_strobe_q;
  logic                    wr_fire_c, icw1_c, data_wr_c, ocw2_c;
  logic [OCW2_CMD_W-1:0]   ocw2_cmd_c;

  // Only the rising cycle of a strobe counts as a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_strobe_q <= 1'b0;
    else        wr_strobe_q <= bus.wr_strobe;
  end

  assign wr_fire_c  = bus.wr_strobe & ~wr_strobe_q;
  assign icw1_c     = wr_fire_c & ~bus.a0 & bus.din[ICW1_ID_BIT];
  assign data_wr_c  = wr_fire_c & bus.a0;
  assign ocw2_c     = wr_fire_c & ~bus.a0 & ~bus.din[ICW1_ID_BIT]
                    & ~bus.din[OCW3_SEL_BIT] & (state_q == S_READY);
  assign ocw2_cmd_c = bus.din[DATA_W-1 -: OCW2_CMD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_UNINIT;
    else        state_q <= state_d;
  end

  // ICW3 is skipped in single mode, ICW4 when ICW1 did not request it
  always_comb begin
    state_d = state_q;
    if (icw1_c) begin
      state_d = S_WAIT_ICW2;
    end else if (data_wr_c) begin
      unique case (state_q)
        S_WAIT_ICW2: begin
          if (!cfg_q.sngl)    state_d = S_WAIT_ICW3;
          else if (cfg_q.ic4) state_d = S_WAIT_ICW4;
          else                state_d = S_READY;
        end
        S_WAIT_ICW3: state_d = cfg_q.ic4 ? S_WAIT_ICW4 : S_READY;
        S_WAIT_ICW4: state_d = S_READY;
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cfg_d      = cfg_q;
    vec_base_d = vec_base_q;
    mask_d     = mask_q;
    aeoi_d     = aeoi_q;
    rotate_d   = rotate_q;
    eoi_d      = 1'b0;
    if (icw1_c) begin
      cfg_d    = '{ltim: bus.din[ICW1_LTIM_BIT],
                   sngl: bus.din[ICW1_SNGL_BIT],
                   ic4:  bus.din[ICW1_IC4_BIT]};
      mask_d   = '0;
      aeoi_d   = 1'b0;
      rotate_d = 1'b0;
    end else if (data_wr_c) begin
      unique case (state_q)
        S_WAIT_ICW2: vec_base_d = bus.din[DATA_W-1 -: VEC_BASE_W];
        S_WAIT_ICW4: aeoi_d     = bus.din[ICW4_AEOI_BIT];
        S_READY:     mask_d     = bus.din;
        default:     ;
      endcase
    end else if (ocw2_c) begin
      // In AEOI mode the interrupt block retires the ISR itself
      unique case (ocw2_cmd_c)
        OCW2_NS_EOI:       eoi_d = ~aeoi_q;
        OCW2_ROT_NS_EOI: begin
          eoi_d    = ~aeoi_q;
          rotate_d = 1'b1;
        end
        OCW2_ROT_AEOI_SET: rotate_d = 1'b1;
        OCW2_ROT_AEOI_CLR: rotate_d = 1'b0;
        default:           ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q      <= '0;
      vec_base_q <= '0;
      mask_q     <= '0;
      aeoi_q     <= 1'b0;
      rotate_q   <= 1'b0;
      eoi_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      vec_base_q <= vec_base_d;
      mask_q     <= mask_d;
      aeoi_q     <= aeoi_d;
      rotate_q   <= rotate_d;
      eoi_q      <= eoi_d;
      ready_q    <= (state_d == S_READY);
    end
  end

  assign bus.ready         = ready_q;
  assign bus.level_or_edge = cfg_q.ltim;
  assign bus.mask          = mask_q;
  assign bus.aeoi          = aeoi_q;
  assign bus.rotate        = rotate_q;
  assign bus.eoi           = eoi_q;

  pic_inta_sequencer u_inta (
    .clk        (clk),
    .rst_n      (rst_n),
    .ready      (ready_q),
    .abort      (icw1_c),
    .inta_n     (bus.inta_n),
    .int_req    (bus.int_req),
    .vec_base   (vec_base_q),
    .isr_level  (bus.isr_level),
    .int_out    (bus.int_out),
    .inta_count (bus.inta_count),
    .dout       (bus.dout),
    .dout_en    (bus.dout_en)
  );

endmodule

// File: tb/tb_pic_control_logic.sv
// Self-checking bench for pic_control_logic: directed scenarios plus random
// register writes checked against a queue-based model of the ICW/OCW rules.
module tb_pic_control_logic;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pic_control_logic_if bus();

  pic_control_logic dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending ICW numbers still expected after ICW1
  bit       m_seen;
  int       m_pend[$];
  bit       m_ltim, m_aeoi, m_rot, m_eoi_exp;
  bit [4:0] m_vec;
  bit [7:0] m_mask;

  function automatic bit m_ready();
    return m_seen && (m_pend.size() == 0);
  endfunction

  function automatic void model_reset();
    m_seen = 0; m_pend.delete(); m_ltim = 0; m_aeoi = 0; m_rot = 0;
    m_eoi_exp = 0; m_vec = '0; m_mask = '0;
  endfunction

  function automatic void model_write(input bit a0, input logic [7:0] d);
    int n;
    m_eoi_exp = 0;
    if (!a0 && d[4]) begin
      m_seen = 1; m_ltim = d[3];
      m_pend.delete();
      m_pend.push_back(2);
      if (!d[1]) m_pend.push_back(3);
      if (d[0])  m_pend.push_back(4);
      m_mask = '0; m_aeoi = 0; m_rot = 0;
    end else if (m_seen && m_pend.size() != 0) begin
      if (a0) begin
        n = m_pend.pop_front();
        if (n == 2) m_vec = d[7:3];
        if (n == 4) m_aeoi = d[1];
      end
    end else if (m_ready()) begin
      if (a0) m_mask = d;
      else if (d[4:3] == 2'b00) begin
        if (d[7:5] == 3'd1 || d[7:5] == 3'd5) m_eoi_exp = !m_aeoi;
        if (d[7:5] == 3'd4 || d[7:5] == 3'd5) m_rot = 1;
        if (d[7:5] == 3'd0) m_rot = 0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One write: a low cycle, then a one-cycle strobe; returns where results show
  task automatic do_write(input bit a0, input logic [7:0] d);
    tick();
    bus.wr_strobe = 1'b1; bus.a0 = a0; bus.din = d;
    tick();
    bus.wr_strobe = 1'b0;
    model_write(a0, d);
  endtask

  task automatic inta_fall();
    bus.inta_n = 1'b0; tick();
  endtask

  task automatic inta_rise();
    bus.inta_n = 1'b1; tick();
  endtask

  task automatic test_reset();
    bus.wr_strobe = 0; bus.a0 = 0; bus.din = '0; bus.int_req = 0;
    bus.isr_level = '0; bus.inta_n = 1;
    model_reset();
    #12;
    n_checks++;
    if ({bus.int_out, bus.dout_en, bus.ready, bus.level_or_edge, bus.aeoi, bus.eoi,
         bus.rotate, bus.mask, bus.dout, bus.inta_count} !== 25'd0)
      $display("FAIL reset_values: got %h want 0", {bus.int_out, bus.dout_en, bus.ready,
               bus.level_or_edge, bus.aeoi, bus.eoi, bus.rotate, bus.mask, bus.dout, bus.inta_count});
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_preinit();
    bus.int_req = 1;
    for (int i = 0; i < 2; i++) begin
      inta_fall();
      n_checks++;
      if (bus.inta_count !== 2'd0) $display("FAIL preinit_count: got %0d want 0", bus.inta_count);
      else n_pass++;
      inta_rise();
    end
    n_checks++;
    if (bus.int_out !== 1'b0) $display("FAIL preinit_int_out: got %b want 0", bus.int_out);
    else n_pass++;
    bus.int_req = 0;
  endtask

  task automatic test_init_aeoi();
    do_write(0, 8'h1B);
    do_write(1, 8'h40);
    n_checks++;
    if (bus.ready !== 1'b0) $display("FAIL aeoi_ready_early: got %b want 0", bus.ready);
    else n_pass++;
    do_write(1, 8'h02);
    n_checks++;
    if ({bus.ready, bus.level_or_edge, bus.aeoi, bus.mask} !== {3'b111, 8'h00})
      $display("FAIL aeoi_init: got %b want 11100000000",
               {bus.ready, bus.level_or_edge, bus.aeoi, bus.mask});
    else n_pass++;
    do_write(0, 8'h20);
    n_checks++;
    if (bus.eoi !== 1'b0) $display("FAIL aeoi_no_eoi: got %b want 0", bus.eoi);
    else n_pass++;
    bus.isr_level = 3'd5; bus.int_req = 1;
    tick();
    inta_fall(); inta_rise(); inta_fall();
    n_checks++;
    if ({bus.inta_count, bus.dout_en, bus.dout} !== {2'd2, 1'b1, 8'h45})
      $display("FAIL aeoi_vector: got %h want 545", {bus.inta_count, bus.dout_en, bus.dout});
    else n_pass++;
    bus.int_req = 0;
    inta_rise();
  endtask

  task automatic test_inta_handshake();
    do_write(0, 8'h13); do_write(1, 8'h20); do_write(1, 8'h00);
    bus.isr_level = 3'd3;
    tick();
    bus.int_req = 1;
    n_checks++;
    if (bus.int_out !== 1'b0) $display("FAIL int_out_before: got %b want 0", bus.int_out);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.int_out !== 1'b1) $display("FAIL int_out_latency: got %b want 1", bus.int_out);
    else n_pass++;
    inta_fall();
    n_checks++;
    if ({bus.inta_count, bus.int_out, bus.dout_en} !== {2'd1, 2'b00})
      $display("FAIL first_fall: got %b want 0100", {bus.inta_count, bus.int_out, bus.dout_en});
    else n_pass++;
    inta_rise();
    n_checks++;
    if ({bus.inta_count, bus.int_out} !== {2'd1, 1'b0})
      $display("FAIL first_rise: got %b want 010", {bus.inta_count, bus.int_out});
    else n_pass++;
    inta_fall();
    n_checks++;
    if ({bus.inta_count, bus.dout_en, bus.dout} !== {2'd2, 1'b1, 8'h23})
      $display("FAIL second_fall: got %h want 523", {bus.inta_count, bus.dout_en, bus.dout});
    else n_pass++;
    bus.int_req = 0;
    inta_rise();
    n_checks++;
    if ({bus.inta_count, bus.dout_en, bus.int_out} !== 4'd0)
      $display("FAIL second_rise: got %b want 0000", {bus.inta_count, bus.dout_en, bus.int_out});
    else n_pass++;
  endtask

  task automatic test_ocw();
    int eoi_cnt;
    do_write(1, 8'hA5);
    n_checks++;
    if (bus.mask !== 8'hA5) $display("FAIL ocw1_mask: got %h want a5", bus.mask);
    else n_pass++;
    do_write(0, 8'h20);
    n_checks++;
    if ({bus.eoi, bus.rotate} !== 2'b10) $display("FAIL ocw2_eoi: got %b want 10", {bus.eoi, bus.rotate});
    else n_pass++;
    tick();
    n_checks++;
    if (bus.eoi !== 1'b0) $display("FAIL eoi_one_cycle: got %b want 0", bus.eoi);
    else n_pass++;
    do_write(0, 8'hA0);
    n_checks++;
    if ({bus.eoi, bus.rotate} !== 2'b11) $display("FAIL ocw2_rot_eoi: got %b want 11", {bus.eoi, bus.rotate});
    else n_pass++;
    do_write(0, 8'h0B);
    n_checks++;
    if ({bus.mask, bus.rotate, bus.eoi} !== {8'hA5, 2'b10})
      $display("FAIL ocw3_ignored: got %h want 296", {bus.mask, bus.rotate, bus.eoi});
    else n_pass++;
    do_write(0, 8'h00);
    n_checks++;
    if ({bus.eoi, bus.rotate} !== 2'b00) $display("FAIL ocw2_rot_clr: got %b want 00", {bus.eoi, bus.rotate});
    else n_pass++;
    tick();
    bus.wr_strobe = 1; bus.a0 = 0; bus.din = 8'h20;
    eoi_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.eoi === 1'b1) eoi_cnt++;
    end
    bus.wr_strobe = 0;
    model_write(0, 8'h20);
    tick();
    n_checks++;
    if (eoi_cnt !== 1) $display("FAIL held_strobe_eoi: got %0d pulses want 1", eoi_cnt);
    else n_pass++;
  endtask

  task automatic test_icw1_abort();
    do_write(1, 8'hFF);
    bus.int_req = 1; bus.isr_level = 3'd1;
    tick();
    inta_fall(); inta_rise();
    // ICW1 coincides with the second INTA falling edge
    bus.wr_strobe = 1; bus.a0 = 0; bus.din = 8'h12; bus.inta_n = 0;
    tick();
    bus.wr_strobe = 0;
    model_write(0, 8'h12);
    n_checks++;
    if ({bus.inta_count, bus.dout_en, bus.mask, bus.ready} !== 12'd0)
      $display("FAIL icw1_abort: got %h want 000", {bus.inta_count, bus.dout_en, bus.mask, bus.ready});
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.inta_count, bus.dout_en, bus.int_out} !== 4'd0)
      $display("FAIL abort_hold: got %b want 0000", {bus.inta_count, bus.dout_en, bus.int_out});
    else n_pass++;
    inta_rise();
    bus.int_req = 0;
    do_write(1, 8'h28);
    n_checks++;
    if (bus.ready !== 1'b1) $display("FAIL abort_wait_icw2: got %b want 1", bus.ready);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit a0, rb, icw, exp_int;
    int kind;
    do_write(0, 8'h1A);
    for (int i = 0; i < 80; i++) begin
      kind = int'($urandom_range(0, 9));
      d = 8'($urandom);
      if (kind == 0)      begin a0 = 0; d[4] = 1'b1; end
      else if (kind <= 5) a0 = 1;
      else                begin a0 = 0; d[4] = 1'b0; end
      bus.int_req = 1'($urandom_range(0, 1));
      rb = m_ready(); icw = (kind == 0);
      do_write(a0, d);
      exp_int = rb && bus.int_req && !icw;
      n_checks++;
      if ({bus.ready, bus.level_or_edge, bus.aeoi, bus.rotate, bus.eoi, bus.int_out, bus.mask} !==
          {m_ready(), m_ltim, m_aeoi, m_rot, m_eoi_exp, exp_int, m_mask})
        $display("FAIL random_%0d a0=%b din=%h: got %b want %b", i, a0, d,
                 {bus.ready, bus.level_or_edge, bus.aeoi, bus.rotate, bus.eoi, bus.int_out, bus.mask},
                 {m_ready(), m_ltim, m_aeoi, m_rot, m_eoi_exp, exp_int, m_mask});
      else n_pass++;
    end
    bus.int_req = 0;
  endtask

  task automatic test_reset_mid();
    do_write(0, 8'h13); do_write(1, 8'h28); do_write(1, 8'h00);
    do_write(0, 8'h80); do_write(1, 8'h3C);
    bus.int_req = 1; bus.isr_level = 3'd6;
    tick();
    inta_fall(); inta_rise(); inta_fall(); inta_rise(); inta_fall();
    n_checks++;
    if ({bus.dout, bus.rotate, bus.inta_count} !== {8'h2E, 1'b1, 2'd1})
      $display("FAIL pre_reset_state: got %h want %h", {bus.dout, bus.rotate, bus.inta_count},
               {8'h2E, 1'b1, 2'd1});
    else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.int_out, bus.dout_en, bus.ready, bus.level_or_edge, bus.aeoi, bus.eoi,
         bus.rotate, bus.mask, bus.dout, bus.inta_count} !== 25'd0)
      $display("FAIL async_reset: got %h want 0", {bus.int_out, bus.dout_en, bus.ready,
               bus.level_or_edge, bus.aeoi, bus.eoi, bus.rotate, bus.mask, bus.dout, bus.inta_count});
    else n_pass++;
    bus.int_req = 0; bus.inta_n = 1;
    model_reset();
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_preinit();
    test_init_aeoi();
    test_inta_handshake();
    test_ocw();
    test_icw1_abort();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
